// File: rtl/spi_seq_pkg.sv
// Shared state encoding and frame geometry for the SPI frame sequencer.
package spi_seq_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, DONE} seq_state_t;

    localparam int FRAME_W   = 40;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 5;
endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: sclk idles low, toggles every CLK_DIV cycles while enabled,
// and flags the clk edge on which sclk rises or falls.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          half_end;

    assign half_end = en && (cnt == CW'(CLK_DIV - 1));
    assign rise     = half_end && !sclk;
    assign fall     = half_end && sclk;

    // Dropping en restarts the next bit with a full low phase.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (half_end) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_frame_sequencer.sv
// SPI master that reads one 40-bit frame per request (start pulse or poll timer)
// and publishes it on frame_o with a one-cycle frame_valid strobe.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SS_SETUP    = 15,
    parameter int unsigned BYTE_GAP    = 10,
    parameter int unsigned SS_HOLD     = 15,
    parameter int unsigned POLL_PERIOD = 10000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [BYTE_W-1:0]  cmd_byte,
    input  logic               miso,
    output logic               ss_n,
    output logic               sclk,
    output logic               mosi,
    output logic               busy,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_o
);
    localparam int unsigned LAST_BIT = BYTE_W * NUM_BYTES - 1;

    seq_state_t         state;
    logic [5:0]         bit_cnt;
    logic [31:0]        wait_cnt;
    logic [31:0]        poll_cnt;
    logic               pending;
    logic               poll_wrap;
    logic [FRAME_W-1:0] tx_sr;
    logic [FRAME_W-1:0] rx_sr;
    logic               sclk_rise;
    logic               sclk_fall;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == SHIFT),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign mosi      = tx_sr[FRAME_W-1];
    assign poll_wrap = en && (poll_cnt == POLL_PERIOD - 1);

    always_ff @(posedge clk) begin
        if (rst || !en || poll_wrap) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == SHIFT && sclk_rise) begin
            rx_sr <= {rx_sr[FRAME_W-2:0], miso};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ss_n        <= 1'b1;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            frame_o     <= '0;
            pending     <= 1'b0;
            tx_sr       <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
        end else begin
            frame_valid <= 1'b0;
            // Any request is parked here; IDLE below overrides it when it starts a frame.
            if (start || poll_wrap) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start || pending) begin
                        pending  <= 1'b0;
                        tx_sr    <= {cmd_byte, {(FRAME_W - BYTE_W){1'b0}}};
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (wait_cnt == SS_SETUP - 1) begin
                        wait_cnt <= '0;
                        state    <= SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        tx_sr <= tx_sr << 1;
                        if (bit_cnt == 6'(LAST_BIT)) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt[2:0] == 3'(BYTE_W - 1)) begin
                                state <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (wait_cnt == BYTE_GAP - 1) begin
                        wait_cnt <= '0;
                        state    <= SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (wait_cnt == SS_HOLD - 1) begin
                        wait_cnt    <= '0;
                        ss_n        <= 1'b1;
                        frame_o     <= rx_sr;
                        frame_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer with a mode-0 slave model and an SPI pin monitor.
module tb_spi_frame_sequencer;
    localparam int CLK_DIV  = 4;
    localparam int SS_SETUP = 15;
    localparam int BYTE_GAP = 10;
    localparam int SS_HOLD  = 15;
    localparam int POLL     = 1000;
    // Edges from the edge that samples start to the cycle showing frame_valid.
    localparam int LAT = SS_SETUP + 2 * 40 * CLK_DIV + 4 * BYTE_GAP + SS_HOLD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cmd_byte = 8'h00;
    logic        miso = 1'b0;
    logic        ss_n, sclk, mosi, busy, frame_valid;
    logic [39:0] frame_o;

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    int unsigned fv_times[$];

    logic [39:0] slave_data = 40'h0;
    int          sidx = 0;
    int          rise_cnt = 0;
    int          run = 0;
    int          stable_err = 0;
    int          sclk_bad = 0;
    int          tail_run = 0;
    int          rises_at_ss_up = 0;
    int          low_run[40];
    logic [39:0] mosi_bits = 40'h0;
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;

    spi_frame_sequencer #(
        .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .BYTE_GAP(BYTE_GAP),
        .SS_HOLD(SS_HOLD), .POLL_PERIOD(POLL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .cmd_byte(cmd_byte), .miso(miso),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .busy(busy),
        .frame_valid(frame_valid), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave drives miso on ss_n fall and after each sclk fall; monitor records pin behaviour.
    always @(negedge clk) begin
        if (ss_n === 1'b0 && prev_ss === 1'b1) begin
            sidx = 39;
            miso = slave_data[39];
            rise_cnt = 0;
            run = 0;
            stable_err = 0;
            mosi_bits = 40'h0;
        end else if (ss_n === 1'b0 && sclk === 1'b0 && prev_sclk === 1'b1) begin
            sidx = sidx - 1;
            miso = (sidx >= 0) ? slave_data[sidx] : 1'b0;
        end
        if (ss_n === 1'b0) begin
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                if (rise_cnt < 40) low_run[rise_cnt] = run;
                if (mosi !== prev_mosi) stable_err++;
                mosi_bits = {mosi_bits[38:0], mosi};
                rise_cnt++;
                run = 0;
            end else if (sclk === 1'b0) begin
                run++;
            end
        end
        if (ss_n === 1'b1 && prev_ss === 1'b0) begin
            tail_run = run;
            rises_at_ss_up = rise_cnt;
        end
        if (ss_n === 1'b1 && sclk !== 1'b0) sclk_bad++;
        if (frame_valid === 1'b1) fv_times.push_back(cyc);
        prev_ss = ss_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        int n0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n got %b exp 1", ss_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", frame_valid); end
        checks++; if (frame_o !== 40'h0) begin errors++; $display("FAIL reset_frame got %h exp 0", frame_o); end
        rst = 1'b0;
        slave_data = 40'hFF_FF_FF_FF_FF;
        pulse_start();
        repeat (40) @(negedge clk);
        checks++; if (ss_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre ss_n/busy got %b%b exp 01", ss_n, busy); end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL abort_ss_n got %b exp 1", ss_n); end
        checks++; if (busy !== 1'b0 || sclk !== 1'b0) begin errors++; $display("FAIL abort_busy_sclk got %b%b exp 00", busy, sclk); end
        n0 = fv_times.size();
        repeat (500) @(negedge clk);
        checks++; if (fv_times.size() != n0) begin errors++; $display("FAIL abort_no_fv got %0d exp %0d", fv_times.size(), n0); end
        checks++; if (frame_o !== 40'h0) begin errors++; $display("FAIL abort_frame got %h exp 0", frame_o); end
    endtask

    task automatic test_single_frame();
        int n0;
        int lat;
        slave_data = 40'hA5_3C_0F_F0_81;
        cmd_byte = 8'h00;
        n0 = fv_times.size();
        pulse_start();
        checks++; if (ss_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL start_ss_busy got %b%b exp 01", ss_n, busy); end
        lat = 0;
        while (frame_valid !== 1'b1 && lat < LAT + 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, LAT); end
        checks++; if (frame_o !== 40'hA53C0FF081) begin errors++; $display("FAIL single_frame got %h exp a53c0ff081", frame_o); end
        checks++; if (busy !== 1'b1 || ss_n !== 1'b1) begin errors++; $display("FAIL done_busy_ss got %b%b exp 11", busy, ss_n); end
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_done fv/busy got %b%b exp 00", frame_valid, busy); end
        repeat (50) @(negedge clk);
        checks++; if (fv_times.size() - n0 != 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", fv_times.size() - n0); end
    endtask

    task automatic test_mosi_clocking();
        int t;
        slave_data = 40'h01_23_45_67_89;
        cmd_byte = 8'h83;
        pulse_start();
        cmd_byte = 8'hFF;
        t = 0;
        while (busy === 1'b1 && t < LAT + 100) begin
            @(negedge clk);
            t++;
        end
        cmd_byte = 8'h00;
        checks++; if (rise_cnt != 40) begin errors++; $display("FAIL sclk_rises got %0d exp 40", rise_cnt); end
        checks++; if (mosi_bits !== {8'h83, 32'h0}) begin errors++; $display("FAIL mosi_bits got %h exp 8300000000", mosi_bits); end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL mosi_stable got %0d exp 0", stable_err); end
        checks++; if (sclk_bad != 0) begin errors++; $display("FAIL sclk_while_idle got %0d exp 0", sclk_bad); end
        checks++; if (low_run[0] != SS_SETUP + CLK_DIV) begin errors++; $display("FAIL setup_low got %0d exp %0d", low_run[0], SS_SETUP + CLK_DIV); end
        checks++; if (tail_run != SS_HOLD) begin errors++; $display("FAIL hold_low got %0d exp %0d", tail_run, SS_HOLD); end
        checks++; if (frame_o !== 40'h0123456789) begin errors++; $display("FAIL frame2 got %h exp 0123456789", frame_o); end
    endtask

    task automatic test_gap_timing();
        int bad;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (low_run[8*k] != BYTE_GAP + CLK_DIV) begin
                errors++;
                $display("FAIL gap_low byte %0d got %0d exp %0d", k, low_run[8*k], BYTE_GAP + CLK_DIV);
            end
        end
        bad = 0;
        for (int i = 1; i < 40; i++) begin
            if (i % 8 != 0 && low_run[i] != CLK_DIV) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bit_low_phase got %0d bad exp 0", bad); end
        checks++; if (rises_at_ss_up != 40) begin errors++; $display("FAIL ss_low_through_gaps got %0d exp 40", rises_at_ss_up); end
    endtask

    task automatic test_auto_poll();
        int unsigned t0;
        slave_data = 40'hDE_AD_BE_EF_42;
        fv_times.delete();
        @(negedge clk) en = 1'b1;
        t0 = cyc;
        while (cyc != t0 + 4000 && cyc < t0 + 5000) @(negedge clk);
        en = 1'b0;
        repeat (1500) @(negedge clk);
        checks++; if (fv_times.size() != 4) begin errors++; $display("FAIL poll_count got %0d exp 4", fv_times.size()); end
        if (fv_times.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fv_times[i] - t0 != 1 + POLL + LAT + i * POLL) begin
                    errors++;
                    $display("FAIL poll_time %0d got %0d exp %0d", i, fv_times[i] - t0, 1 + POLL + LAT + i * POLL);
                end
            end
        end
        checks++; if (frame_o !== 40'hDEADBEEF42) begin errors++; $display("FAIL poll_frame got %h exp deadbeef42", frame_o); end
    endtask

    task automatic test_collision();
        int unsigned t0;
        slave_data = 40'h11_22_33_44_55;
        fv_times.delete();
        @(negedge clk) en = 1'b1;
        t0 = cyc;
        while (cyc != t0 + 999 && cyc < t0 + 2000) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (cyc != t0 + 1010 && cyc < t0 + 2000) @(negedge clk);
        en = 1'b0;
        repeat (1000) @(negedge clk);
        checks++; if (fv_times.size() != 1) begin errors++; $display("FAIL collision_count got %0d exp 1", fv_times.size()); end
        if (fv_times.size() >= 1) begin
            checks++;
            if (fv_times[0] - t0 != 1000 + LAT) begin
                errors++;
                $display("FAIL collision_time got %0d exp %0d", fv_times[0] - t0, 1000 + LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        slave_data = 40'h66_77_88_99_AA;
        fv_times.delete();
        pulse_start();
        repeat (30) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            repeat (50) @(negedge clk);
        end
        repeat (1200) @(negedge clk);
        checks++; if (fv_times.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", fv_times.size()); end
        if (fv_times.size() >= 2) begin
            checks++;
            if (fv_times[1] - fv_times[0] != LAT + 2) begin
                errors++;
                $display("FAIL b2b_spacing got %0d exp %0d", fv_times[1] - fv_times[0], LAT + 2);
            end
        end
        checks++; if (frame_o !== 40'h66778899AA) begin errors++; $display("FAIL b2b_frame got %h exp 66778899aa", frame_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_mosi_clocking();
        test_gap_timing();
        test_auto_poll();
        test_collision();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
